fml_burst_master: RTL and testbench
===================================

Name: fml_burst_master

Overview:
- FML initiator that turns one local command into one 4-beat, 64-bit FML burst (32 bytes) and moves the data.
- It is the master-side counterpart of the arbiter's ack logic: it drives fml_stb/we/adr/sel/do, waits for fml_ack, then streams write data out or captures read data.
- Used by DMA-style cores (video fetch, texture, sound) that need whole-line accesses to SDRAM.

Parameters:
- fml_depth, 26, FML byte-address width; the burst-aligned address keeps 5 LSBs at zero.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge
- sys_rst_n  in  1  synchronous reset, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid & cmd_ready
- cmd_we  in  1  1 = write burst, 0 = read burst
- cmd_adr  in  fml_depth-5  line address, upper bits of fml_adr
- wb_we  in  1  write-buffer load strobe
- wb_idx  in  2  write-buffer beat index
- wb_data  in  64  write-buffer data
- wb_sel  in  8  write-buffer byte enables
- rd_valid  out  1  read beat valid, one per beat
- rd_idx  out  2  read beat index
- rd_data  out  64  read beat data
- done  out  1  one-cycle pulse at burst completion
- fml_adr  out  fml_depth  {line, 5'b0}
- fml_stb  out  1  FML strobe
- fml_we  out  1  FML write enable
- fml_ack  in  1  FML acknowledge
- fml_sel  out  8  byte enables of current write beat
- fml_do  out  64  write data
- fml_di  in  64  read data

Behaviour:
- Reset (sys_rst_n=0 at an edge): state IDLE. All outputs 0 except cmd_ready=1. Beat counter 0. Write buffer contents undefined.
- Reset mid-burst aborts immediately: fml_stb drops the following cycle and no done is issued.
- Write buffer: 4 x (64+8) registers, written when wb_we=1 at index wb_idx.
  - Loading is legal in any state, but the caller must not modify it between cmd accept and done; the buffer is not double-buffered.
- State IDLE:
  - cmd_ready=1.
  - On accept, register cmd_we and cmd_adr, then go to REQ.
- State REQ:
  - fml_stb=1, fml_we=registered we, fml_adr stable.
  - Hold until fml_ack=1 is sampled; fml_stb stays 1 in the ack cycle itself.
  - Next state DATA with beat=0; fml_stb=0 from the following cycle.
  - fml_ack outside REQ is ignored.
- State DATA, 4 cycles, beat counter 0..3:
  - Write: fml_do = buffer[beat].data and fml_sel = buffer[beat].sel in each DATA cycle. Beat 0 is the cycle immediately after the ack cycle.
  - Read: fml_di is registered each DATA cycle. rd_valid=1, rd_idx=beat and rd_data=captured value appear one cycle later, so read beat k is visible at ack+2+k.
  - Outside write DATA, fml_sel=0 and fml_do=0.
  - After beat 3, go to DONE.
- State DONE:
  - done=1 for one cycle. For reads, the last rd_valid appears in this same cycle.
  - Next state IDLE.
- Latency from command accept to done, with ack W cycles after REQ entry (W>=0): 1 + W + 1 + 4 cycles.
  - Minimum is 6 cycles, i.e. ack in the first REQ cycle.
- Back-to-back: a new command is accepted only in IDLE. Minimum issue interval is 7 cycles with immediate ack.
- The beat counter is 2 bits and wraps 3->0 on leaving DATA. No other arithmetic.
- fml_adr low 5 bits are constant 0. cmd_adr is captured only at accept and cannot change mid-burst.

Decomposition:
- Shared package/header:
  - burst length constant FML_BURST=4;
  - beat-index width 2;
  - state encodings IDLE/REQ/DATA/DONE;
  - byte-offset width 5.
- One natural sub-module, fml_burst_wbuf: the 4-entry data+sel register file with one write port and a combinational read by beat index.
- The top holds the FSM, counter and read capture.

Test Plan:
- Reset then idle:
  - hold sys_rst_n=0 for 2 cycles, then release;
  - expect cmd_ready=1, fml_stb=0, done=0, rd_valid=0.
- Write burst, immediate ack:
  - load beats 0..3 = 0x1111..., 0x2222..., 0x3333..., 0x4444... with sel 0xFF, 0x0F, 0xF0, 0x01;
  - cmd_we=1, cmd_adr=0x12345, fml_ack in first REQ cycle;
  - expect fml_adr=0x2468A0, fml_do/fml_sel in order on cycles ack+1..ack+4, done at ack+5.
- Read burst, delayed ack:
  - fml_ack arrives 3 cycles after stb rises; fml_di = 0xA0..0xA3 on ack+1..ack+4;
  - expect rd_valid with idx 0..3 and matching data on ack+2..ack+5, done at ack+5, fml_stb held exactly 4 cycles.
- Spurious ack and command during busy:
  - pulse fml_ack in IDLE and in DATA, and assert cmd_valid throughout;
  - expect no state change from the ack, cmd_ready=0 while busy, next command accepted the cycle after done.
- Reset mid-operation:
  - deassert sys_rst_n during DATA beat 1 of a read;
  - expect no further rd_valid, no done, fml_stb=0, cmd_ready=1 after reset.
- Back-to-back:
  - two write commands with immediate acks;
  - expect second fml_stb rise exactly 7 cycles after the first.

Source files
------------

// File: rtl/fml_burst_pkg.sv
// Shared constants and types for the FML burst master: burst geometry,
// FSM state encoding and the write-buffer entry layout.
package fml_burst_pkg;

    localparam int FML_BURST = 4;
    localparam int BEAT_W    = 2;
    localparam int OFFSET_W  = 5;
    localparam int DATA_W    = 64;
    localparam int SEL_W     = 8;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FML_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  sel;
    } wbuf_entry_t;

endpackage

// File: rtl/fml_burst_wbuf.sv
// Four-entry write buffer (data + byte enables) with one write port and an
// asynchronous read port indexed by the current beat.
module fml_burst_wbuf
    import fml_burst_pkg::*;
(
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [BEAT_W-1:0] wr_idx_i,
    input  wbuf_entry_t       wr_entry_i,
    input  logic [BEAT_W-1:0] rd_idx_i,
    output wbuf_entry_t       rd_entry_o
);

    // Contents are deliberately not reset; the caller reloads before each write burst.
    wbuf_entry_t mem_q [FML_BURST];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wr_idx_i] <= wr_entry_i;
        end
    end

    assign rd_entry_o = mem_q[rd_idx_i];

endmodule

// File: rtl/fml_burst_master.sv
// FML initiator: turns one local command into a single 4-beat 64-bit burst,
// streaming write data from the buffer or capturing read beats.
module fml_burst_master
    import fml_burst_pkg::*;
#(
    parameter int fml_depth = 26
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,

    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_we,
    input  logic [fml_depth-OFFSET_W-1:0] cmd_adr,

    input  logic                          wb_we,
    input  logic [BEAT_W-1:0]             wb_idx,
    input  logic [DATA_W-1:0]             wb_data,
    input  logic [SEL_W-1:0]              wb_sel,

    output logic                          rd_valid,
    output logic [BEAT_W-1:0]             rd_idx,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          done,

    output logic [fml_depth-1:0]          fml_adr,
    output logic                          fml_stb,
    output logic                          fml_we,
    input  logic                          fml_ack,
    output logic [SEL_W-1:0]              fml_sel,
    output logic [DATA_W-1:0]             fml_do,
    input  logic [DATA_W-1:0]             fml_di
);

    state_e                        state_q;
    logic [BEAT_W-1:0]             beat_q;
    logic [BEAT_W-1:0]             beat_d;
    logic                          we_q;
    logic [fml_depth-OFFSET_W-1:0] line_q;
    logic                          stb_q;
    logic                          ready_q;
    logic                          done_q;
    logic                          rd_valid_q;
    logic [BEAT_W-1:0]             rd_idx_q;
    logic [DATA_W-1:0]             rd_data_q;

    wbuf_entry_t                   wr_entry;
    wbuf_entry_t                   wr_beat;
    logic                          wr_active;

    assign wr_entry = {wb_data, wb_sel};

    fml_burst_wbuf u_wbuf (
        .clk_i      (sys_clk),
        .we_i       (wb_we),
        .wr_idx_i   (wb_idx),
        .wr_entry_i (wr_entry),
        .rd_idx_i   (beat_q),
        .rd_entry_o (wr_beat)
    );

    // The counter wraps 3->0 as the burst leaves DATA, so REQ->DATA needs no reload in steady state.
    assign beat_d = beat_q + BEAT_W'(1);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            we_q       <= 1'b0;
            line_q     <= '0;
            stb_q      <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_idx_q   <= '0;
            rd_data_q  <= '0;
        end else begin
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid && ready_q) begin
                        we_q    <= cmd_we;
                        line_q  <= cmd_adr;
                        stb_q   <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (fml_ack) begin
                        stb_q   <= 1'b0;
                        beat_q  <= '0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    // Read beats surface one cycle late, so the last one lands in DONE.
                    if (!we_q) begin
                        rd_valid_q <= 1'b1;
                        rd_idx_q   <= beat_q;
                        rd_data_q  <= fml_di;
                    end
                    beat_q <= beat_d;
                    if (beat_q == LAST_BEAT) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wr_active = (state_q == DATA) && we_q;

    assign cmd_ready = ready_q;
    assign done      = done_q;
    assign rd_valid  = rd_valid_q;
    assign rd_idx    = rd_idx_q;
    assign rd_data   = rd_data_q;
    assign fml_adr   = {line_q, {OFFSET_W{1'b0}}};
    assign fml_stb   = stb_q;
    assign fml_we    = we_q & stb_q;
    assign fml_do    = wr_active ? wr_beat.data : '0;
    assign fml_sel   = wr_active ? wr_beat.sel  : '0;

endmodule

// File: tb/tb_fml_burst_master.sv
// Self-checking bench for fml_burst_master: a table of bursts plus hand-written
// busy, back-to-back and mid-burst reset sequences, with beat scoreboards.
`timescale 1ns/1ps
module tb_fml_burst_master;

    localparam int FML_DEPTH = 26;
    localparam int LINE_W    = FML_DEPTH - 5;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  sel;
    } wbeat_t;

    typedef struct packed {
        logic [1:0]  idx;
        logic [63:0] data;
    } rbeat_t;

    typedef struct {
        logic                 we;
        logic [LINE_W-1:0]    adr;
        int                   ackWait;
        logic                 spurious;
        logic [FML_DEPTH-1:0] expAdr;
        int                   expLat;
        int                   expStb;
    } vec_t;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst_n;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_we;
    logic [LINE_W-1:0]    cmd_adr;
    logic                 wb_we;
    logic [1:0]           wb_idx;
    logic [63:0]          wb_data;
    logic [7:0]           wb_sel;
    logic                 rd_valid;
    logic [1:0]           rd_idx;
    logic [63:0]          rd_data;
    logic                 done;
    logic [FML_DEPTH-1:0] fml_adr;
    logic                 fml_stb;
    logic                 fml_we;
    logic                 fml_ack;
    logic [7:0]           fml_sel;
    logic [63:0]          fml_do;
    logic [63:0]          fml_di;

    int     checks    = 0;
    int     failures  = 0;
    int     cycleNo   = 0;
    int     beatsLeft = 0;
    logic   tbCmdWe   = 1'b0;
    wbeat_t expWrQ[$];
    rbeat_t expRdQ[$];
    wbeat_t shadow[4];
    vec_t   vecs[4];
    rbeat_t monR;
    wbeat_t monW;

    fml_burst_master #(.fml_depth(FML_DEPTH)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .wb_we     (wb_we),
        .wb_idx    (wb_idx),
        .wb_data   (wb_data),
        .wb_sel    (wb_sel),
        .rd_valid  (rd_valid),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .done      (done),
        .fml_adr   (fml_adr),
        .fml_stb   (fml_stb),
        .fml_we    (fml_we),
        .fml_ack   (fml_ack),
        .fml_sel   (fml_sel),
        .fml_do    (fml_do),
        .fml_di    (fml_di)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
        cycleNo++;
    endtask

    // Beat monitor: read beats are popped when the DUT shows them, write beats
    // are expected on the four cycles that follow a sampled stb&ack.
    always @(negedge sys_clk) begin
        if (rd_valid === 1'b1) begin
            if (expRdQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL rd_unexpected actual rd_valid=1 idx=%0d expected rd_valid=0", rd_idx);
            end else begin
                monR = expRdQ.pop_front();
                checkOutput("rd_idx", 64'(rd_idx), 64'(monR.idx));
                checkOutput("rd_data", rd_data, monR.data);
            end
        end
        if (beatsLeft > 0 && tbCmdWe) begin
            if (expWrQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL wr_unexpected actual beat with empty queue expected none");
            end else begin
                monW = expWrQ.pop_front();
                checkOutput("fml_do", fml_do, monW.data);
                checkOutput("fml_sel", 64'(fml_sel), 64'(monW.sel));
            end
        end else begin
            checkOutput("fml_do_quiet", fml_do, 64'(0));
            checkOutput("fml_sel_quiet", 64'(fml_sel), 64'(0));
        end
        if (sys_rst_n !== 1'b1) beatsLeft = 0;
        else if (beatsLeft > 0) beatsLeft--;
        if (sys_rst_n === 1'b1 && fml_stb === 1'b1 && fml_ack === 1'b1) beatsLeft = 4;
    end

    task automatic loadBeat(input int idx, input logic [63:0] d, input logic [7:0] s);
        wb_we   = 1'b1;
        wb_idx  = idx[1:0];
        wb_data = d;
        wb_sel  = s;
        tick();
        wb_we   = 1'b0;
        wb_idx  = 2'($urandom);
        wb_data = {$urandom, $urandom};
        wb_sel  = 8'($urandom);
        shadow[idx] = '{d, s};
    endtask

    task automatic loadRandom();
        for (int b = 0; b < 4; b++) loadBeat(b, {$urandom, $urandom}, 8'($urandom));
    endtask

    // Starts in an IDLE cycle, issues one command, plays the FML slave side and
    // returns in the IDLE cycle after done.
    task automatic applyStimulus(input vec_t v, input logic keepValid, output int stbRise);
        int cyc     = 0;
        int stbCnt  = 0;
        int doneCyc = -1;
        int beat;
        stbRise = -1;
        checkOutput("cmd_ready_idle", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1;
        cmd_we    = v.we;
        cmd_adr   = v.adr;
        tbCmdWe   = v.we;
        if (v.we) for (int b = 0; b < 4; b++) expWrQ.push_back(shadow[b]);
        fml_ack = 1'b0;
        fml_di  = {$urandom, $urandom};
        tick();
        cyc = 1;
        if (!keepValid) cmd_valid = 1'b0;
        while (doneCyc < 0 && cyc < 40) begin
            if (fml_stb === 1'b1) begin
                stbCnt++;
                if (stbRise < 0) stbRise = cycleNo;
                checkOutput("fml_adr", 64'(fml_adr), 64'(v.expAdr));
                checkOutput("fml_we", 64'(fml_we), 64'(v.we));
            end
            checkOutput("cmd_ready_busy", 64'(cmd_ready), 64'(0));
            if (done === 1'b1) begin
                doneCyc = cyc;
            end else begin
                fml_ack = (cyc == 1 + v.ackWait) || (v.spurious && cyc == 3 + v.ackWait);
                beat = cyc - 2 - v.ackWait;
                fml_di = {$urandom, $urandom};
                if (!v.we && beat >= 0 && beat < 4) expRdQ.push_back('{beat[1:0], fml_di});
                tick();
                cyc++;
            end
        end
        fml_ack = 1'b0;
        if (doneCyc < 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL done_timeout actual no done within 40 cycles expected done at %0d", v.expLat);
        end else begin
            checkOutput("done_latency", 64'(doneCyc), 64'(v.expLat));
        end
        checkOutput("stb_cycles", 64'(stbCnt), 64'(v.expStb));
        tick();
        checkOutput("done_pulse", 64'(done), 64'(0));
        checkOutput("cmd_ready_after_done", 64'(cmd_ready), 64'(1));
        checkOutput("stb_after_done", 64'(fml_stb), 64'(0));
        checkOutput("rd_queue_drained", 64'(expRdQ.size()), 64'(0));
        checkOutput("wr_queue_drained", 64'(expWrQ.size()), 64'(0));
    endtask

    initial begin
        int riseA;
        int riseB;
        vec_t busyVec;
        vec_t followVec;
        vec_t b2bVec;
        vec_t recVec;
        logic [63:0] d0;

        vecs[0] = '{1'b1, 21'h12345,  0, 1'b0, 26'h02468A0, 6, 1};
        vecs[1] = '{1'b0, 21'h00000,  3, 1'b0, 26'h0000000, 9, 4};
        vecs[2] = '{1'b0, 21'h1FFFFF, 1, 1'b1, 26'h3FFFFE0, 7, 2};
        vecs[3] = '{1'b1, 21'h0AAAA,  2, 1'b1, 26'h0155540, 8, 3};
        busyVec   = '{1'b0, 21'h00F0F, 2, 1'b1, 26'h001E1E0, 8, 3};
        followVec = '{1'b1, 21'h00001, 0, 1'b0, 26'h0000020, 6, 1};
        b2bVec    = '{1'b1, 21'h10203, 0, 1'b0, 26'h0204060, 6, 1};
        recVec    = '{1'b0, 21'h00055, 1, 1'b0, 26'h0000AA0, 7, 2};

        sys_rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = '0;
        wb_we     = 1'b0;
        wb_idx    = '0;
        wb_data   = '0;
        wb_sel    = '0;
        fml_ack   = 1'b0;
        fml_di    = '0;

        tick();
        checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        checkOutput("rst_fml_stb", 64'(fml_stb), 64'(0));
        tick();
        sys_rst_n = 1'b1;
        tick();
        checkOutput("idle_cmd_ready", 64'(cmd_ready), 64'(1));
        checkOutput("idle_fml_stb", 64'(fml_stb), 64'(0));
        checkOutput("idle_done", 64'(done), 64'(0));
        checkOutput("idle_rd_valid", 64'(rd_valid), 64'(0));
        checkOutput("idle_fml_adr", 64'(fml_adr), 64'(0));

        $display("[TB] spurious ack while idle");
        fml_ack = 1'b1;
        repeat (2) begin
            tick();
            checkOutput("spurious_idle_stb", 64'(fml_stb), 64'(0));
            checkOutput("spurious_idle_ready", 64'(cmd_ready), 64'(1));
        end
        fml_ack = 1'b0;

        $display("[TB] table of bursts");
        for (int i = 0; i < 4; i++) begin
            if (vecs[i].we) begin
                if (i == 0) begin
                    loadBeat(0, 64'h1111111111111111, 8'hFF);
                    loadBeat(1, 64'h2222222222222222, 8'h0F);
                    loadBeat(2, 64'h3333333333333333, 8'hF0);
                    loadBeat(3, 64'h4444444444444444, 8'h01);
                end else begin
                    loadRandom();
                end
            end
            applyStimulus(vecs[i], 1'b0, riseA);
        end

        $display("[TB] command held during busy burst");
        loadRandom();
        applyStimulus(busyVec, 1'b1, riseA);
        applyStimulus(followVec, 1'b0, riseB);
        checkOutput("accept_after_done", 64'(riseB - riseA), 64'(9));

        $display("[TB] back-to-back writes");
        loadRandom();
        applyStimulus(b2bVec, 1'b0, riseA);
        applyStimulus(b2bVec, 1'b0, riseB);
        checkOutput("b2b_interval", 64'(riseB - riseA), 64'(7));

        $display("[TB] reset during read beat 1");
        checkOutput("rst_test_ready", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 21'h00055;
        tbCmdWe   = 1'b0;
        tick();
        cmd_valid = 1'b0;
        checkOutput("rst_test_req_stb", 64'(fml_stb), 64'(1));
        fml_ack = 1'b1;
        tick();
        fml_ack = 1'b0;
        d0 = {$urandom, $urandom};
        fml_di = d0;
        expRdQ.push_back('{2'd0, d0});
        tick();
        fml_di = {$urandom, $urandom};
        sys_rst_n = 1'b0;
        tick();
        checkOutput("midrst_stb", 64'(fml_stb), 64'(0));
        checkOutput("midrst_ready", 64'(cmd_ready), 64'(1));
        checkOutput("midrst_rd_valid", 64'(rd_valid), 64'(0));
        checkOutput("midrst_done", 64'(done), 64'(0));
        sys_rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput("post_rst_done", 64'(done), 64'(0));
            checkOutput("post_rst_rd_valid", 64'(rd_valid), 64'(0));
            checkOutput("post_rst_stb", 64'(fml_stb), 64'(0));
        end
        checkOutput("midrst_rd_drained", 64'(expRdQ.size()), 64'(0));

        $display("[TB] recovery read");
        applyStimulus(recVec, 1'b0, riseA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        checks++;
        failures++;
        $display("[TB] FAIL watchdog actual time limit reached expected bench completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
